// File: rtl/lcd_vram_arbiter_pkg.sv
// Shared constants and types for the LCD VRAM arbiter.
package lcd_vram_pkg;

  localparam int unsigned VRAM_AW  = 8;
  localparam int unsigned VRAM_DW  = 4;
  localparam int unsigned STARVE_W = 4;

  // Two equal banks; the first address past bank 1 is the first invalid one.
  localparam logic [VRAM_AW-1:0] BANK_OFFSET = 8'h50;
  localparam logic [VRAM_AW-1:0] VRAM_SIZE   = BANK_OFFSET + BANK_OFFSET;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VIDEO,
    OWN_CPU_RD,
    OWN_CPU_WR
  } owner_t;

  function automatic logic is_cpu(input owner_t o);
    return (o == OWN_CPU_RD) || (o == OWN_CPU_WR);
  endfunction

endpackage

// File: rtl/lcd_vram_arbiter_if.sv
// Video, CPU and VRAM-macro signals seen by the arbiter.
interface lcd_vram_arbiter_if #(
  parameter int unsigned AW = lcd_vram_pkg::VRAM_AW,
  parameter int unsigned DW = lcd_vram_pkg::VRAM_DW
);
  logic [AW-1:0] video_addr;
  logic          video_active;
  logic [DW-1:0] video_data;
  logic          video_data_valid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter side.
  modport slave (
    input  video_addr, video_active, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output video_data, video_data_valid, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  // Requesters and VRAM macro side.
  modport master (
    output video_addr, video_active, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  video_data, video_data_valid, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/lcd_vram_arbiter_starve_ctr.sv
// Saturating count of cycles a CPU request has waited without a grant.
module lcd_vram_starve_ctr #(
  parameter int unsigned         CNT_W = 4,
  parameter logic [CNT_W-1:0]    LIMIT = CNT_W'(8)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_hit_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on grant, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit_o = (cnt_q == LIMIT);
endmodule

// File: rtl/lcd_vram_arbiter.sv
// Single-port LCD VRAM arbiter: video fetches have priority, CPU is
// guaranteed a slot after a bounded wait. One slot decision per cycle,
// two-stage owner pipeline matching the registered RAM address.
module lcd_vram_arbiter #(
  parameter int unsigned                        ADDR_WIDTH   = lcd_vram_pkg::VRAM_AW,
  parameter int unsigned                        DATA_WIDTH   = lcd_vram_pkg::VRAM_DW,
  parameter logic [ADDR_WIDTH-1:0]              VRAM_SIZE    = lcd_vram_pkg::VRAM_SIZE,
  parameter logic [lcd_vram_pkg::STARVE_W-1:0]  STARVE_LIMIT = 4'd8
) (
  input  logic              clk,
  input  logic              reset_n,
  lcd_vram_arbiter_if.slave bus
);
  import lcd_vram_pkg::*;

  owner_t                grant;
  logic                  vid_need, cpu_pend, cpu_grant, starve_hit;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic                  slot_oor;

  owner_t                own1_q, own1_d;
  logic                  oor1_q, oor1_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  logic [DATA_WIDTH-1:0] rdata_or_zero;
  logic [DATA_WIDTH-1:0] video_data_q, video_data_d;
  logic                  video_valid_q, video_valid_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_ack_q, cpu_ack_d;

  logic                  cache_valid_q, cache_valid_d;
  logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
  logic                  cpu_busy_q, cpu_busy_d;

  // Slot decision: starved CPU first, then a new video address, then CPU.
  always_comb begin
    vid_need = bus.video_active && (!cache_valid_q || (bus.video_addr != cache_addr_q));
    cpu_pend = bus.cpu_req && !cpu_busy_q;
    grant    = OWN_NONE;
    if (cpu_pend && starve_hit) begin
      grant = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end else if (vid_need) begin
      grant = OWN_VIDEO;
    end else if (cpu_pend) begin
      grant = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end
    cpu_grant = is_cpu(grant);
    slot_addr = (grant == OWN_VIDEO) ? bus.video_addr : bus.cpu_addr;
    slot_oor  = (slot_addr >= VRAM_SIZE);
  end

  lcd_vram_starve_ctr #(
    .CNT_W (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_i       (cpu_grant),
    .inc_i       (cpu_pend && !cpu_grant),
    .limit_hit_o (starve_hit)
  );

  // Stage 1: drive the RAM port; out-of-range slots leave the port untouched.
  always_comb begin
    own1_d      = grant;
    oor1_d      = slot_oor;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if ((grant != OWN_NONE) && !slot_oor) begin
      ram_addr_d = slot_addr;
      if (grant == OWN_CPU_WR) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = bus.cpu_wdata;
      end
    end
  end

  // Stage 2: route read data to whoever owned the slot; out-of-range reads give 0.
  always_comb begin
    rdata_or_zero = oor1_q ? '0 : bus.ram_rdata;
    video_valid_d = (own1_q == OWN_VIDEO);
    cpu_ack_d     = is_cpu(own1_q);
    video_data_d  = video_valid_d ? rdata_or_zero : video_data_q;
    cpu_rdata_d   = (own1_q == OWN_CPU_RD) ? rdata_or_zero : cpu_rdata_q;
  end

  // Fetch cache and CPU busy flag; busy drops after the ack cycle so a held
  // request is not granted twice.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    if (grant == OWN_VIDEO) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = bus.video_addr;
    end else if ((grant == OWN_CPU_WR) && (bus.cpu_addr == cache_addr_q)) begin
      cache_valid_d = 1'b0;
    end
    cpu_busy_d = cpu_busy_q;
    if (cpu_grant) begin
      cpu_busy_d = 1'b1;
    end else if (cpu_ack_q) begin
      cpu_busy_d = 1'b0;
    end
  end

  // All state; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own1_q        <= OWN_NONE;
      oor1_q        <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      video_data_q  <= '0;
      video_valid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cpu_busy_q    <= 1'b0;
    end else begin
      own1_q        <= own1_d;
      oor1_q        <= oor1_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      video_data_q  <= video_data_d;
      video_valid_q <= video_valid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cpu_busy_q    <= cpu_busy_d;
    end
  end

  assign bus.ram_addr         = ram_addr_q;
  assign bus.ram_we           = ram_we_q;
  assign bus.ram_wdata        = ram_wdata_q;
  assign bus.video_data       = video_data_q;
  assign bus.video_data_valid = video_valid_q;
  assign bus.cpu_rdata        = cpu_rdata_q;
  assign bus.cpu_ack          = cpu_ack_q;
endmodule

// File: tb/tb_lcd_vram_arbiter.sv
// Scoreboard bench for lcd_vram_arbiter with a VRAM model.
`timescale 1ns/1ps
module tb_lcd_vram_arbiter;
  import lcd_vram_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lcd_vram_arbiter_if bus ();

  lcd_vram_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       is_rd;
    logic [3:0] data;
  } cpu_exp_t;

  int         checks = 0;
  int         errors = 0;
  int         ram_we_cnt = 0;
  logic [3:0] ram [0:255];
  logic [3:0] exp_vid_q [$];
  cpu_exp_t   exp_cpu_q [$];

  // Initial VRAM content: (addr*7+3) mod 16.
  function automatic logic [3:0] init_val(input int i);
    return 4'((i * 7 + 3) & 15);
  endfunction

  // VRAM model: address already registered by the arbiter, write on the edge.
  initial for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
      ram_we_cnt        <= ram_we_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    if (bus.video_data_valid) begin
      if (exp_vid_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL video_unexpected: got pulse with data %0h, required no pulse", bus.video_data);
      end else begin
        chk("video_data", bus.video_data, exp_vid_q.pop_front());
      end
    end
    if (bus.cpu_ack) begin
      if (exp_cpu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_ack_unexpected: got ack, required none");
      end else begin
        cpu_exp_t e;
        e = exp_cpu_q.pop_front();
        if (e.is_rd) chk("cpu_rdata", bus.cpu_rdata, e.data);
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [7:0] a, input logic [3:0] wd,
                            input logic [3:0] erd, input int elat, input string nm);
    int n;
    cpu_exp_t e;
    n = 0;
    e.is_rd = !we;
    e.data  = erd;
    exp_cpu_q.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 40);
    bus.cpu_req = 1'b0;
    chk($sformatf("%s_latency", nm), n, elat);
  endtask

  initial begin
    #200000;
    checks++; errors++;
    $display("FAIL watchdog: got timeout, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [3:0] t1_exp [4];
    logic [3:0] t3_exp [12];
    int n;
    t1_exp = '{4'h3, 4'hA, 4'h1, 4'h8};
    for (int k = 0; k < 12; k++) t3_exp[k] = init_val(16 + k);

    bus.video_addr   = '0;
    bus.video_active = 1'b0;
    bus.cpu_req      = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ram_addr",   bus.ram_addr, 0);
    chk("rst_ram_we",     bus.ram_we, 0);
    chk("rst_ram_wdata",  bus.ram_wdata, 0);
    chk("rst_cpu_ack",    bus.cpu_ack, 0);
    chk("rst_cpu_rdata",  bus.cpu_rdata, 0);
    chk("rst_video_data", bus.video_data, 0);
    chk("rst_video_vld",  bus.video_data_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Video stepping every 11 cycles, no CPU.
    bus.video_active = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.video_addr = 8'(a);
      exp_vid_q.push_back(t1_exp[a]);
      @(negedge clk);
      chk("t1_valid_n1", bus.video_data_valid, 0);
      @(negedge clk);
      chk("t1_valid_n2", bus.video_data_valid, 1);
      chk("t1_data_n2", bus.video_data, t1_exp[a]);
      repeat (9) @(negedge clk);
    end
    chk("t1_vid_q_empty", exp_vid_q.size(), 0);
    chk("t1_no_writes", ram_we_cnt, 0);

    // Idle video: write then read, grants 3 cycles apart.
    bus.video_active = 1'b0;
    @(negedge clk);
    cpu_access(1'b1, 8'h05, 4'hA, 4'h0, 2, "t2_wr");
    cpu_access(1'b0, 8'h05, 4'h0, 4'hA, 3, "t2_rd");
    chk("t2_one_write", ram_we_cnt, 1);
    repeat (2) @(negedge clk);

    // Video changing every cycle; CPU starved until the 9th pending cycle.
    bus.video_active = 1'b1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          if (k == 10) begin
            chk("t3_hold_valid", bus.video_data_valid, 0);
            chk("t3_hold_data", bus.video_data, 4'h4);
          end
          bus.video_addr = 8'(16 + k);
          if (k != 8) exp_vid_q.push_back(t3_exp[k]);
          @(negedge clk);
        end
      end
      cpu_access(1'b0, 8'h30, 4'h0, 4'h3, 10, "t3_starve");
    join
    repeat (4) @(negedge clk);
    chk("t3_vid_q_empty", exp_vid_q.size(), 0);

    // Cached address overwritten by CPU forces one refetch.
    bus.video_addr = 8'h23;
    exp_vid_q.push_back(4'h8);
    repeat (5) @(negedge clk);
    exp_vid_q.push_back(4'h7);
    cpu_access(1'b1, 8'h23, 4'h7, 4'h0, 2, "t4_wr");
    repeat (5) @(negedge clk);
    chk("t4_video_data", bus.video_data, 4'h7);
    chk("t4_vid_q_empty", exp_vid_q.size(), 0);

    // Same-cycle video need and CPU write to that address: old value first.
    fork
      begin
        bus.video_addr = 8'h40;
        exp_vid_q.push_back(4'h3);
        exp_vid_q.push_back(4'hC);
      end
      cpu_access(1'b1, 8'h40, 4'hC, 4'h0, 3, "t5_same_wr");
    join
    repeat (5) @(negedge clk);
    chk("t5_video_data", bus.video_data, 4'hC);
    chk("t5_vid_q_empty", exp_vid_q.size(), 0);

    // Out-of-range CPU read and video address.
    fork
      begin
        bus.video_addr = 8'hB0;
        exp_vid_q.push_back(4'h0);
      end
      cpu_access(1'b0, 8'hA5, 4'h0, 4'h0, 3, "t6_oor_rd");
    join
    repeat (4) @(negedge clk);
    chk("t6_no_ram_write", ram_we_cnt, 3);
    chk("t6_ram_addr_held", bus.ram_addr, 8'h40);
    chk("t6_vid_q_empty", exp_vid_q.size(), 0);

    // Reset one cycle after a CPU write grant aborts it; retry completes.
    bus.video_active = 1'b0;
    repeat (2) @(negedge clk);
    begin
      cpu_exp_t e;
      e.is_rd = 1'b0;
      e.data  = 4'h0;
      exp_cpu_q.push_back(e);
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = BANK_OFFSET + 8'h06;
    bus.cpu_wdata = 4'h9;
    @(negedge clk);
    chk("t7_we_before_rst", bus.ram_we, 1);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_ram_we",     bus.ram_we, 0);
    chk("t7_rst_ram_addr",   bus.ram_addr, 0);
    chk("t7_rst_ram_wdata",  bus.ram_wdata, 0);
    chk("t7_rst_cpu_ack",    bus.cpu_ack, 0);
    chk("t7_rst_video_data", bus.video_data, 0);
    @(negedge clk);
    chk("t7_aborted_no_write", ram[8'h56], 4'hD);
    chk("t7_no_ack_in_rst", bus.cpu_ack, 0);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpu_ack && n < 40);
    bus.cpu_req = 1'b0;
    chk("t7_retry_latency", n, 2);
    repeat (2) @(negedge clk);
    chk("t7_ram_written", ram[8'h56], 4'h9);
    cpu_access(1'b0, 8'h56, 4'h0, 4'h9, 2, "t7_readback");
    repeat (4) @(negedge clk);
    chk("end_vid_q_empty", exp_vid_q.size(), 0);
    chk("end_cpu_q_empty", exp_cpu_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
